// File: rtl/pacman_pkg.sv
// Shared pacman types: monster and global-phase encodings, chase limit,
// and the saturating eat counter helper.
package pacman_pkg;

    typedef enum logic [1:0] {
        M_HOUSE  = 2'd0,
        M_ACTIVE = 2'd1,
        M_FRIGHT = 2'd2,
        M_EATEN  = 2'd3
    } monster_mode_e;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_SCATTER = 2'd1,
        PH_CHASE   = 2'd2
    } phase_e;

    // After this many CHASE entries the chase phase never ends.
    localparam int unsigned CHASE_LIMIT  = 3;
    localparam int unsigned NUM_MONSTERS = 4;
    localparam int unsigned EAT_MAX      = 4;

    function automatic logic [2:0] sat_eat_count(input logic [2:0] base,
                                                 input logic [2:0] add);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, add};
        return (sum > 4'(EAT_MAX)) ? 3'(EAT_MAX) : sum[2:0];
    endfunction

endpackage

// File: rtl/monster_mode_scheduler_fsm.sv
// Per-monster mode FSM with its own house release timer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// M_HOUSE  | in the house; leaves when the release timer runs out
// M_ACTIVE | roaming; a power pellet frightens it
// M_FRIGHT | frightened; eaten -> EATEN, fright expiry -> ACTIVE
// M_EATEN  | eyes travelling home; home flag -> HOUSE and re-arm timer
//
// The release timer is a down-counter. Zero means "not armed": a monster
// sitting in the house with a zero timer waits for its predecessor to leave.
module monster_state_fsm
    import pacman_pkg::*;
#(
    parameter bit FIRST_MONSTER = 1'b0,
    parameter int RELEASE_SEC   = 3
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          game_start_i,
    input  logic          tick_i,
    input  logic          pellet_i,
    input  logic          eaten_i,
    input  logic          home_i,
    input  logic          fright_expire_i,
    input  logic          pred_leave_i,
    output monster_mode_e mode_o,
    output logic          leave_o
);

    localparam int RW = $clog2(RELEASE_SEC + 1);

    monster_mode_e mode_q, mode_d;
    logic [RW-1:0] rel_q, rel_d;

    // State and release-timer registers.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            mode_q <= M_HOUSE;
            rel_q  <= '0;
        end else begin
            mode_q <= mode_d;
            rel_q  <= rel_d;
        end
    end

    // Next state; gameStart overrides every other event.
    always_comb begin
        mode_d  = mode_q;
        rel_d   = rel_q;
        leave_o = 1'b0;
        if (game_start_i) begin
            mode_d  = FIRST_MONSTER ? M_ACTIVE : M_HOUSE;
            rel_d   = pred_leave_i ? RW'(RELEASE_SEC) : '0;
            leave_o = FIRST_MONSTER;
        end else begin
            case (mode_q)
                M_HOUSE: begin
                    if (rel_q == '0) begin
                        if (pred_leave_i) rel_d = RW'(RELEASE_SEC);
                    end else if (tick_i) begin
                        if (rel_q == RW'(1)) begin
                            mode_d  = M_ACTIVE;
                            rel_d   = '0;
                            leave_o = 1'b1;
                        end else begin
                            rel_d = rel_q - RW'(1);
                        end
                    end
                end
                M_ACTIVE: begin
                    if (pellet_i) mode_d = M_FRIGHT;
                end
                M_FRIGHT: begin
                    if (eaten_i)              mode_d = M_EATEN;
                    else if (fright_expire_i) mode_d = M_ACTIVE;
                end
                M_EATEN: begin
                    if (home_i) begin
                        mode_d = M_HOUSE;
                        rel_d  = RW'(RELEASE_SEC);
                    end
                end
                default: mode_d = M_HOUSE;
            endcase
        end
    end

    assign mode_o = mode_q;

endmodule

// File: rtl/monster_mode_scheduler.sv
// Monster mode scheduler: global scatter/chase phasing, shared fright timer,
// eat counter, and four chained monster FSMs.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// PH_IDLE    | after reset, waiting for gameStart
// PH_SCATTER | scatter phase, SCATTER_SEC unfrozen ticks
// PH_CHASE   | chase phase, CHASE_SEC ticks; permanent after the last entry
//
// The phase counter counts down; zero means "not running" (IDLE or the
// permanent final chase). It freezes while any monster is frightened.
module monster_mode_scheduler
    import pacman_pkg::*;
#(
    parameter int SCATTER_SEC = 7,
    parameter int CHASE_SEC   = 20,
    parameter int FRIGHT_SEC  = 6,
    parameter int RELEASE_SEC = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       gameStart,
    input  logic       oneSecPulse,
    input  logic       powerPellet,
    input  logic [3:0] monsterEaten,
    input  logic [3:0] monsterHome,
    output logic [7:0] monsterMode,
    output logic       chaseMode,
    output logic       frightBlink,
    output logic [2:0] eatCount
);

    localparam int PHASE_MAX = (SCATTER_SEC > CHASE_SEC) ? SCATTER_SEC : CHASE_SEC;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int FW        = $clog2(FRIGHT_SEC + 1);

    phase_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [1:0]    chases_q, chases_d;
    logic [FW-1:0] fright_q, fright_d;
    logic [2:0]    eat_q, eat_d;
    logic          chase_q, blink_q;

    monster_mode_e mode_w [NUM_MONSTERS];
    logic [3:0]    leave_w;
    logic [3:0]    pred_leave;
    logic [3:0]    eaten_ok;
    logic [2:0]    n_eaten;
    logic          any_fright;
    logic          fright_expire;
    logic          unused_last_leave;

    // Each monster is released by the one before it leaving the house.
    assign pred_leave        = {leave_w[2:0], 1'b0};
    assign unused_last_leave = leave_w[3];

    // A pellet reload on the same cycle cancels expiry.
    assign fright_expire = oneSecPulse && !powerPellet && (fright_q == FW'(1));

    for (genvar gi = 0; gi < NUM_MONSTERS; gi++) begin : g_monster
        monster_state_fsm #(
            .FIRST_MONSTER(gi == 0),
            .RELEASE_SEC  (RELEASE_SEC)
        ) u_monster (
            .clk            (clk),
            .resetN         (resetN),
            .game_start_i   (gameStart),
            .tick_i         (oneSecPulse),
            .pellet_i       (powerPellet),
            .eaten_i        (monsterEaten[gi]),
            .home_i         (monsterHome[gi]),
            .fright_expire_i(fright_expire),
            .pred_leave_i   (pred_leave[gi]),
            .mode_o         (mode_w[gi]),
            .leave_o        (leave_w[gi])
        );
    end

    // Eat hits only count for monsters that are currently frightened.
    always_comb begin
        any_fright  = 1'b0;
        eaten_ok    = '0;
        monsterMode = '0;
        for (int i = 0; i < NUM_MONSTERS; i++) begin
            if (mode_w[i] == M_FRIGHT) begin
                any_fright  = 1'b1;
                eaten_ok[i] = monsterEaten[i];
            end
            monsterMode[2*i +: 2] = mode_w[i];
        end
        n_eaten = 3'(eaten_ok[0]) + 3'(eaten_ok[1]) + 3'(eaten_ok[2]) + 3'(eaten_ok[3]);
    end

    // Global phase, fright timer and eat counter next state.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        chases_d = chases_q;
        fright_d = fright_q;
        eat_d    = eat_q;
        if (gameStart) begin
            state_d  = PH_SCATTER;
            phase_d  = PW'(SCATTER_SEC);
            chases_d = '0;
            fright_d = '0;
            eat_d    = '0;
        end else begin
            if (oneSecPulse && !any_fright && (phase_q != '0)) begin
                if (phase_q == PW'(1)) begin
                    if (state_q == PH_SCATTER) begin
                        state_d  = PH_CHASE;
                        chases_d = chases_q + 2'd1;
                        phase_d  = (chases_q == 2'(CHASE_LIMIT - 1)) ? '0 : PW'(CHASE_SEC);
                    end else begin
                        state_d = PH_SCATTER;
                        phase_d = PW'(SCATTER_SEC);
                    end
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            if (powerPellet) begin
                fright_d = FW'(FRIGHT_SEC);
                eat_d    = sat_eat_count(3'd0, n_eaten);
            end else begin
                if (oneSecPulse && (fright_q != '0)) fright_d = fright_q - FW'(1);
                eat_d = sat_eat_count(eat_q, n_eaten);
            end
        end
    end

    // Registered state and outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= PH_IDLE;
            phase_q  <= '0;
            chases_q <= '0;
            fright_q <= '0;
            eat_q    <= '0;
            chase_q  <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            chases_q <= chases_d;
            fright_q <= fright_d;
            eat_q    <= eat_d;
            chase_q  <= (state_d == PH_CHASE);
            blink_q  <= (fright_d != '0) && (int'(fright_d) <= 2);
        end
    end

    assign chaseMode   = chase_q;
    assign frightBlink = blink_q;
    assign eatCount    = eat_q;

endmodule

// File: tb/tb_monster_mode_scheduler.sv
// Scoreboard bench: the driver steps a behavioural game model and queues the
// expected outputs; the monitor pops one entry after every clock edge.
module tb_monster_mode_scheduler;

    localparam int SCATTER_SEC = 7;
    localparam int CHASE_SEC   = 20;
    localparam int FRIGHT_SEC  = 6;
    localparam int RELEASE_SEC = 3;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       gameStart = 1'b0;
    logic       oneSecPulse = 1'b0;
    logic       powerPellet = 1'b0;
    logic [3:0] monsterEaten = '0;
    logic [3:0] monsterHome = '0;
    logic [7:0] monsterMode;
    logic       chaseMode;
    logic       frightBlink;
    logic [2:0] eatCount;

    always #5 clk = ~clk;

    monster_mode_scheduler #(
        .SCATTER_SEC(SCATTER_SEC),
        .CHASE_SEC  (CHASE_SEC),
        .FRIGHT_SEC (FRIGHT_SEC),
        .RELEASE_SEC(RELEASE_SEC)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .gameStart   (gameStart),
        .oneSecPulse (oneSecPulse),
        .powerPellet (powerPellet),
        .monsterEaten(monsterEaten),
        .monsterHome (monsterHome),
        .monsterMode (monsterMode),
        .chaseMode   (chaseMode),
        .frightBlink (frightBlink),
        .eatCount    (eatCount)
    );

    typedef struct packed {
        logic [7:0] mode;
        logic       chase;
        logic       blink;
        logic [2:0] eat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: modes 0 house, 1 active, 2 fright, 3 eaten; phase 0 idle, 1 scatter, 2 chase.
    int m_mode[4];
    int m_rel[4];
    int m_phase, m_left, m_chases, m_fl, m_ec;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit gs, input bit tick, input bit pel,
                              input bit [3:0] eat, input bit [3:0] home, output exp_t e);
        int  old_mode[4];
        int  old_rel[4];
        bit  left_now[4];
        bit  any_f;
        int  n;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin m_mode[i] = 0; m_rel[i] = 0; end
            m_phase = 0; m_left = 0; m_chases = 0; m_fl = 0; m_ec = 0;
        end else if (gs) begin
            for (int i = 0; i < 4; i++) begin
                m_mode[i] = (i == 0) ? 1 : 0;
                m_rel[i]  = (i == 1) ? RELEASE_SEC : 0;
            end
            m_phase = 1; m_left = SCATTER_SEC; m_chases = 0; m_fl = 0; m_ec = 0;
        end else begin
            old_mode = m_mode;
            old_rel  = m_rel;
            any_f = 0;
            n = 0;
            for (int i = 0; i < 4; i++) if (old_mode[i] == 2) any_f = 1;
            for (int i = 0; i < 4; i++) begin
                left_now[i] = 0;
                case (old_mode[i])
                    0: if (old_rel[i] > 0 && tick) begin
                           m_rel[i] = old_rel[i] - 1;
                           if (m_rel[i] == 0) begin m_mode[i] = 1; left_now[i] = 1; end
                       end
                    1: if (pel) m_mode[i] = 2;
                    2: if (eat[i]) begin m_mode[i] = 3; n++; end
                       else if (!pel && tick && m_fl == 1) m_mode[i] = 1;
                    default: if (home[i]) begin m_mode[i] = 0; m_rel[i] = RELEASE_SEC; end
                endcase
            end
            for (int i = 1; i < 4; i++)
                if (left_now[i-1] && old_mode[i] == 0 && old_rel[i] == 0) m_rel[i] = RELEASE_SEC;
            if (tick && !any_f && m_phase != 0 && !(m_phase == 2 && m_chases >= 3)) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_phase == 1) begin m_phase = 2; m_chases++; m_left = CHASE_SEC; end
                    else begin m_phase = 1; m_left = SCATTER_SEC; end
                end
            end
            if (pel) begin
                m_fl = FRIGHT_SEC;
                m_ec = n;
            end else begin
                if (tick && m_fl > 0) m_fl--;
                m_ec = (m_ec + n > 4) ? 4 : m_ec + n;
            end
        end
        for (int i = 0; i < 4; i++) e.mode[2*i +: 2] = 2'(m_mode[i]);
        e.chase = (m_phase == 2);
        e.blink = (m_fl >= 1 && m_fl <= 2);
        e.eat   = 3'(m_ec);
    endtask

    task automatic drive(input bit rst_n, input bit gs, input bit tick, input bit pel,
                         input bit [3:0] eat, input bit [3:0] home);
        exp_t e;
        @(negedge clk);
        resetN       = rst_n;
        gameStart    = gs;
        oneSecPulse  = tick;
        powerPellet  = pel;
        monsterEaten = eat;
        monsterHome  = home;
        model_step(rst_n, gs, tick, pel, eat, home, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1, 0, 0, 0, 4'h0, 4'h0);
    endtask

    task automatic ticks(input int count);
        for (int i = 0; i < count; i++) begin
            drive(1, 0, 1, 0, 4'h0, 4'h0);
            idle(2);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("monsterMode", monsterMode, e.mode);
                check("chaseMode", {7'd0, chaseMode}, {7'd0, e.chase});
                check("frightBlink", {7'd0, frightBlink}, {7'd0, e.blink});
                check("eatCount", {5'd0, eatCount}, {5'd0, e.eat});
            end
        end
    end

    initial begin
        int tick_div;
        int pel_div;
        bit [3:0] eat_r;
        bit [3:0] home_r;
        int drain;

        // Reset with junk on the inputs.
        drive(0, 1, 1, 1, 4'hF, 4'hF);
        drive(0, 0, 1, 1, 4'hF, 4'hF);
        idle(2);
        settle();
        check("reset_mode", monsterMode, 8'h00);

        // Round start and release chain.
        drive(1, 1, 0, 0, 4'h0, 4'h0);
        settle();
        check("start_m0", monsterMode, 8'h01);
        ticks(3);
        settle();
        check("release_m1", monsterMode, 8'h05);
        ticks(7);
        settle();
        check("release_all", monsterMode, 8'h55);
        check("chase_after7", {7'd0, chaseMode}, 8'd1);

        // Fright: eat monster 2 then 0, then let it expire.
        drive(1, 0, 0, 1, 4'h0, 4'h0);
        drive(1, 0, 0, 0, 4'b0100, 4'h0);
        drive(1, 0, 0, 0, 4'b0001, 4'h0);
        settle();
        check("eat_two", {5'd0, eatCount}, 8'd2);
        ticks(6);
        settle();
        check("fright_expire", monsterMode, 8'b0111_0111);

        // Pellet with tick, then all eaten bits while 1 and 3 are frightened.
        drive(1, 0, 1, 1, 4'h0, 4'h0);
        drive(1, 0, 0, 0, 4'hF, 4'h0);
        settle();
        check("eat_all_bits", monsterMode, 8'hFF);
        check("eat_all_cnt", {5'd0, eatCount}, 8'd2);
        drive(1, 0, 0, 0, 4'h0, 4'b0010);
        ticks(4);

        // Reset in the middle of fright.
        drive(1, 0, 0, 0, 4'h0, 4'hF);
        ticks(3);
        drive(1, 0, 0, 1, 4'h0, 4'h0);
        drive(0, 0, 0, 0, 4'h0, 4'h0);
        settle();
        check("midfright_reset", {monsterMode[6:0], frightBlink}, 8'h00);
        idle(3);

        // Randomised rounds.
        for (int seg = 0; seg < 6; seg++) begin
            tick_div = 2 + seg;
            pel_div  = (seg == 0) ? 0 : 60 + 10 * seg;
            drive(1, 1, 0, 0, 4'h0, 4'h0);
            for (int c = 0; c < 2800; c++) begin
                eat_r  = '0;
                home_r = '0;
                for (int b = 0; b < 4; b++) begin
                    eat_r[b]  = ($urandom_range(0, 5) == 0);
                    home_r[b] = ($urandom_range(0, 7) == 0);
                end
                drive(($urandom_range(0, 3999) != 0),
                      ($urandom_range(0, 2999) == 0),
                      ($urandom_range(0, tick_div - 1) == 0),
                      (pel_div != 0) && ($urandom_range(0, pel_div - 1) == 0),
                      eat_r, home_r);
            end
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        check("scoreboard_drain", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/monster_mode_scheduler.md
MONSTER_MODE_SCHEDULER -- requirements
Module: monster_mode_scheduler

Interface
REQ-001 Parameter SCATTER_SEC, default 7, scatter phase length in oneSecPulse ticks.
REQ-002 Parameter CHASE_SEC, default 20, chase phase length in ticks.
REQ-003 Parameter FRIGHT_SEC, default 6, frightened duration in ticks.
REQ-004 Parameter RELEASE_SEC, default 3, ticks between successive monster releases from the house.
REQ-005 Port clk  input  1  system clock; reset is synchronous and active-low.
REQ-006 Port resetN  input  1  synchronous active-low reset.
REQ-007 Port gameStart  input  1  one-cycle pulse; starts or restarts a round.
REQ-008 Port oneSecPulse  input  1  one-cycle tick, once per second.
REQ-009 Port powerPellet  input  1  one-cycle pulse; pacman ate a power pellet.
REQ-010 Port monsterEaten  input  4  bit i pulses when pacman collides with monster i.
REQ-011 Port monsterHome  input  4  bit i high when monster i's eyes reach the house.
REQ-012 Port monsterMode  output  8  2 bits per monster i at [2i+1:2i]: HOUSE=0, ACTIVE=1, FRIGHT=2, EATEN=3.
REQ-013 Port chaseMode  output  1  1 = global chase, 0 = scatter (or idle).
REQ-014 Port frightBlink  output  1  high during the last 2 ticks of fright.
REQ-015 Port eatCount  output  3  monsters eaten in the current fright, 0..4.

Function
REQ-016 Global FSM states SHALL be IDLE, SCATTER, CHASE; gameStart from any state SHALL enter SCATTER with the phase counter cleared.
REQ-017 SCATTER SHALL last SCATTER_SEC ticks and then go to CHASE; CHASE SHALL last CHASE_SEC ticks and then go to SCATTER; after the 3rd CHASE entry, CHASE SHALL be permanent.
REQ-018 The phase tick counter SHALL freeze while any monster is in FRIGHT.
REQ-019 Each monster FSM SHALL be HOUSE->ACTIVE->FRIGHT->EATEN->HOUSE, with FRIGHT->ACTIVE on timeout.
REQ-020 Release: monster 0 SHALL go HOUSE->ACTIVE on gameStart; monster k SHALL leave RELEASE_SEC ticks after monster k-1 left; a monster that returns via EATEN SHALL re-release after RELEASE_SEC ticks.
REQ-021 powerPellet SHALL move every ACTIVE monster to FRIGHT, load the fright counter with FRIGHT_SEC, and clear eatCount; a pellet during fright SHALL reload the counter and clear eatCount.
REQ-022 HOUSE and EATEN monsters SHALL ignore powerPellet.
REQ-023 monsterEaten[i] SHALL take effect only when monster i is in FRIGHT; it moves monster i to EATEN and increments eatCount by the number of such bits, saturating at 4.
REQ-024 Extra monsterEaten bits for monsters in other states SHALL be ignored.
REQ-025 monsterHome[i] SHALL move monster i from EATEN to HOUSE; it is ignored in other states.
REQ-026 On fright counter expiry, remaining FRIGHT monsters SHALL go to ACTIVE, and eatCount SHALL hold until the next pellet or gameStart.
REQ-027 Simultaneous events:
- powerPellet with oneSecPulse: the load wins and that tick is not consumed.
- monsterEaten with fright expiry: eaten wins.
- gameStart with any other input: gameStart wins.
REQ-028 All outputs SHALL be registered, with 1-cycle latency from an input event to the output change.
REQ-029 frightBlink SHALL be high while the fright counter is at 2 or less and nonzero.

Reset
REQ-030 While resetN=0 at a clk edge:
- global FSM SHALL be IDLE;
- all monsters SHALL be HOUSE (monsterMode=0);
- chaseMode=0, frightBlink=0, eatCount=0;
- all counters SHALL be cleared.
REQ-031 Reset mid-fright or mid-release SHALL abandon the activity; nothing resumes until gameStart.

Structure
REQ-032 The monster-state enum, global-phase enum, and the 3-chase limit SHALL live in the shared pacman package.
REQ-033 The per-monster FSM plus release timer SHALL be the sub-module monster_state_fsm, instantiated 4 times.

Verification
REQ-034 Round start: reset, gameStart, 10 ticks -> monster0 ACTIVE at cycle+1, monster1 ACTIVE after tick 3, monster2 after tick 6, monster3 after tick 9.
REQ-035 Phase timing: gameStart, then 7 ticks -> chaseMode=1; 20 more ticks -> chaseMode=0; after the 3rd chase entry, 100 ticks -> chaseMode stays 1.
REQ-036 Fright: all monsters ACTIVE, powerPellet, eat monsters 2 then 0 -> eatCount 1 then 2; after 6 ticks monsters 1 and 3 ACTIVE; frightBlink high for ticks 4-6; phase counter frozen throughout.
REQ-037 Simultaneity: monsterEaten=4'b1111 while monsters 0 and 1 are FRIGHT -> only those two go EATEN, eatCount=2; powerPellet with oneSecPulse -> counter=6.
REQ-038 Return: monster EATEN, monsterHome pulse -> HOUSE, then ACTIVE after 3 ticks; resetN low mid-fright -> all outputs zero at the next edge.
